// File: rtl/fp_to_fixed_pipe.sv
// fp_to_fixed_pipe: three-stage FP32 -> unsigned fixed-point converter
// (classify, align, saturate) with valid/ready flow control on both sides.
// Truncates toward zero; reports zero/invalid/tiny/huge/inexact status flags.
module fp_to_fixed_pipe #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_status
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_INF,
    CLS_NAN,
    CLS_NORMAL
  } cls_t;

  // Exponent at which the integer LSB of the output lines up with the FP32 significand LSB.
  localparam int BIAS_SHIFT = 150 - FRAC_BITS;
  // First exponent whose value no longer fits in 32 - FRAC_BITS integer bits.
  localparam int HUGE_EXP   = 159 - FRAC_BITS;

  localparam logic [7:0] ST_ZERO    = 8'h01;
  localparam logic [7:0] ST_INVALID = 8'h04;
  localparam logic [7:0] ST_TINY    = 8'h08;
  localparam logic [7:0] ST_HUGE    = 8'h10;
  localparam logic [7:0] ST_INEXACT = 8'h20;

  // A stalled output freezes the whole pipe; no bubble collapsing.
  logic advance;
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // ---------------- stage 1: classify ----------------
  logic        v1, sign1;
  logic [7:0]  e1;
  logic [23:0] sig1;
  cls_t        cls1;
  cls_t        cls_in;

  // Decode the operand class from the raw exponent and mantissa fields.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    cls_in = CLS_NORMAL;
    if (in_data[30:23] == 8'd0)
      cls_in = (in_data[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
    else if (in_data[30:23] == 8'hFF)
      cls_in = (in_data[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
  end

  // Register sign, exponent, significand with hidden bit, and class.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so out_data/out_status read 0 out of reset.
    if (!rst_n) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      e1    <= 8'd0;
      sig1  <= 24'd0;
      cls1  <= CLS_ZERO;
    end else if (advance) begin
      // NOTE: non-blocking assignments give every stage the pre-edge value of its predecessor.
      v1    <= in_valid;
      sign1 <= in_data[31];
      e1    <= in_data[30:23];
      sig1  <= {in_data[30:23] != 8'd0, in_data[22:0]};
      cls1  <= cls_in;
    end
  end

  // ---------------- stage 2: align ----------------
  logic              v2, sign2, huge2, inex2;
  cls_t              cls2;
  logic [31:0]       mag2;

  logic signed [9:0] sh;
  logic [9:0]        nsh;
  logic [55:0]       left_wide;
  logic [55:0]       right_wide;
  logic [31:0]       al_mag;
  logic              al_inex;
  logic              al_huge;

  // Shift the significand so bit FRAC_BITS carries weight 1.0, tracking lost bits.
  always_comb begin
    sh         = $signed({2'b00, e1}) - $signed(10'(BIAS_SHIFT));
    nsh        = 10'(-sh);
    left_wide  = {32'd0, sig1} << sh[8:0];
    right_wide = {sig1, 32'd0} >> nsh[4:0];
    al_mag     = 32'd0;
    al_inex    = 1'b0;
    // The wide upper bits can only be set when the exponent test already flags huge.
    al_huge    = (e1 >= 8'(HUGE_EXP)) | (~sh[9] & (|left_wide[55:32]));
    if (!sh[9]) begin
      al_mag = left_wide[31:0];
    end else if (nsh >= 10'd24) begin
      al_mag  = 32'd0;
      al_inex = 1'b1;
    end else begin
      al_mag  = {8'd0, right_wide[55:32]};
      al_inex = |right_wide[31:0];
    end
  end

  // Register the aligned magnitude with its range and exactness flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      cls2  <= CLS_ZERO;
      huge2 <= 1'b0;
      inex2 <= 1'b0;
      mag2  <= 32'd0;
    end else if (advance) begin
      v2    <= v1;
      sign2 <= sign1;
      cls2  <= cls1;
      huge2 <= al_huge;
      inex2 <= al_inex;
      mag2  <= al_mag;
    end
  end

  // ---------------- stage 3: saturate and flag ----------------
  logic [31:0] res_data;
  logic [7:0]  res_status;

  // Pick the result and status by descending priority of the special cases.
  always_comb begin
    res_data   = 32'd0;
    res_status = 8'd0;
    if (cls2 == CLS_NAN) begin
      res_data   = 32'hFFFF_FFFF;
      res_status = ST_INVALID;
    end else if (sign2 && cls2 != CLS_ZERO) begin
      res_status = ST_INVALID;
    end else if (cls2 == CLS_INF) begin
      res_data   = 32'hFFFF_FFFF;
      res_status = ST_HUGE;
    end else if (huge2) begin
      res_data   = 32'hFFFF_FFFF;
      res_status = ST_HUGE | ST_INEXACT;
    end else if (cls2 == CLS_ZERO) begin
      res_status = ST_ZERO;
    end else if (cls2 == CLS_DENORM || mag2 == 32'd0) begin
      res_status = ST_TINY | ST_INEXACT | ST_ZERO;
    end else begin
      res_data   = mag2;
      res_status = inex2 ? ST_INEXACT : 8'd0;
    end
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 32'd0;
      out_status <= 8'd0;
    end else if (advance) begin
      out_valid  <= v2;
      out_data   <= res_data;
      out_status <= res_status;
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// tb_fp_to_fixed_pipe: directed and randomized checks of fp_to_fixed_pipe
// against a real-arithmetic reference model and an in-order scoreboard.
module tb_fp_to_fixed_pipe;

  localparam int F = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_status;

  fp_to_fixed_pipe #(.FRAC_BITS(F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Reference: value of the float as a real, scaled by 2^F, truncated toward zero.
  function automatic logic [39:0] model(input logic [31:0] x);
    logic        s;
    int          e;
    int          m;
    real         sig;
    real         scaled;
    real         fl;
    logic [31:0] d;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255 && m != 0) return {8'h04, 32'hFFFF_FFFF};
    if (s && !(e == 0 && m == 0)) return {8'h04, 32'h0};
    if (e == 255) return {8'h10, 32'hFFFF_FFFF};
    if (e == 0 && m == 0) return {8'h01, 32'h0};
    sig    = real'(m) + ((e != 0) ? 8388608.0 : 0.0);
    scaled = sig * (2.0 ** ((e == 0 ? 1 : e) - 150 + F));
    if (scaled >= 4294967296.0) return {8'h30, 32'hFFFF_FFFF};
    fl = $floor(scaled);
    if (fl == 0.0) return {8'h29, 32'h0};
    d = 32'(longint'(fl));
    return {(scaled != fl) ? 8'h20 : 8'h00, d};
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic [7:0]  prev_status = 8'd0;
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, prev_data);
        check("hold_status", {24'd0, out_status}, {24'd0, prev_status});
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e[31:0]);
          check("sb_status", {24'd0, out_status}, {24'd0, e[39:32]});
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_status = out_status;
    end
  end

  task automatic push(input logic [31:0] x);
    int w = 0;
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w == 100) check("push_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single operand into an empty pipe: latency, data and status against fixed values.
  task automatic directed(input string tag, input logic [31:0] x,
                          input logic [31:0] wd, input logic [7:0] ws);
    int lat = 0;
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_data"}, out_data, wd);
    check({tag, "_status"}, {24'd0, out_status}, {24'd0, ws});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] sp[8];
    int          sel;
    sp  = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
            32'h7FC0_0000, 32'h0000_0001, 32'h477F_FF00, 32'h4780_0000};
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return $urandom;
      7:       return sp[$urandom_range(0, 7)];
      8:       return {1'b0, 8'($urandom_range(0, 30)), 23'($urandom)};
      9:       return {1'b1, 31'($urandom)};
      default: return {1'b0, 8'($urandom_range(100, 165)), 23'($urandom)};
    endcase
  endfunction

  logic        done = 1'b0;
  logic [31:0] held;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_status", {24'd0, out_status}, {24'd0, 8'h00});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed values
    directed("one",      32'h3F80_0000, 32'h0001_0000, 8'h00);
    directed("pi",       32'h4049_0FDB, 32'h0003_243F, 8'h20);
    directed("max",      32'h477F_FF00, 32'hFFFF_0000, 8'h00);
    directed("ovf",      32'h4780_0000, 32'hFFFF_FFFF, 8'h30);
    directed("pinf",     32'h7F80_0000, 32'hFFFF_FFFF, 8'h10);
    directed("lsb",      32'h3780_0000, 32'h0000_0001, 8'h00);
    directed("sub_lsb",  32'h3700_0000, 32'h0000_0000, 8'h29);
    directed("denorm",   32'h0000_0001, 32'h0000_0000, 8'h29);
    directed("negzero",  32'h8000_0000, 32'h0000_0000, 8'h01);
    directed("negone",   32'hBF80_0000, 32'h0000_0000, 8'h04);
    directed("qnan",     32'h7FC0_0000, 32'hFFFF_FFFF, 8'h04);
    drain();

    // Backpressure: 6 back-to-back operands, 5-cycle stall once results appear
    fork
      begin
        for (int i = 0; i < 6; i++) push(gen());
      end
      begin
        int k = 0;
        do begin
          @(posedge clk);
          #1;
          k++;
        end while (!out_valid && k < 50);
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operands in flight
    push(32'h3F80_0000);
    push(32'h4000_0000);
    push(32'h4040_0000);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_status", {24'd0, out_status}, {24'd0, 8'h00});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    directed("post_rst", 32'h4120_0000, 32'h000A_0000, 8'h00);
    drain();

    // Randomized stream with random backpressure
    fork
      begin
        repeat (400) push(gen());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed_pipe.md
Name: fp_to_fixed_pipe

Overview:
- Pipelined converter from IEEE-754 single precision to unsigned fixed point, FRAC_BITS fractional bits in a 32-bit word. It is the inverse of the softmax datapath's fixed-to-float normaliser.
- Sits after the FP exp/ln stages and returns results to the fixed-point accumulator/divider domain.
- Three register stages (classify, align, saturate) with valid/ready flow control on both sides.
- Truncates toward zero and reports DW-style status flags per result.

Parameters:
- FRAC_BITS, 16, number of fractional bits in the output (default Q16.16); legal range 1..31.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is presented
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  32  FP32 operand {sign, exp[7:0], man[22:0]}
- out_valid  output  1  out_data/out_status hold a result
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  32  unsigned fixed-point result
- out_status  output  8  bit0 zero, bit2 invalid, bit3 tiny, bit4 huge, bit5 inexact; bits 1,6,7 always 0

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_data 0, out_status 0. Any in-flight operands are discarded.
- Handshake and stall:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready. When stalled, every stage holds; otherwise every stage advances.
  - in_ready = ~stall (combinational from out_ready). No bubble collapsing.
  - out_data and out_status stay stable while out_valid & ~out_ready.
- Latency: exactly 3 cycles from the accepting edge to out_valid when unstalled. Throughput is 1 per cycle. Order is preserved.
- Stage 1 (classify): register the sign, e = exp, and sig = {exp!=0, man} (24 bits). Classes:
  - zero: exp==0 & man==0
  - denorm: exp==0 & man!=0
  - inf: exp==255 & man==0
  - nan: exp==255 & man!=0
  - normal: everything else
- Stage 2 (align): sh = e − (150 − FRAC_BITS), signed 10-bit.
  - If sh ≥ 0: mag = sig << sh.
  - If sh < 0: mag = sig >> −sh; inexact = any bit shifted out is nonzero.
  - If sh ≤ −24: mag = 0 and inexact = 1.
  - huge_pre = (e ≥ 127 + 32 − FRAC_BITS).
- Stage 3 (saturate and flag), priority top-down:
  - nan → out_data FFFFFFFF, invalid.
  - negative & not zero (includes −inf, −denorm) → 0, invalid.
  - +inf → FFFFFFFF, huge.
  - huge_pre → FFFFFFFF, huge | inexact.
  - ±zero → 0, zero (sign ignored).
  - denorm → 0, tiny | inexact | zero.
  - normal with mag==0 → 0, tiny | inexact | zero.
  - otherwise → mag, with inexact if truncation lost bits.
- Width rules: the shift is performed in a 56-bit intermediate, and the low 32 bits are kept only when not huge_pre. There is no overflow wrap under any input.
- Simultaneous in and out handshakes in the same cycle are legal. The pipeline advances and the new operand enters stage 1.
- Reset mid-stream: out_valid falls asynchronously. After release, the first accepted operand appears 3 cycles later.

Test Plan:
- Single operand at FRAC_BITS=16:
  - 3F800000 (1.0) → out_data 00010000, status 00, out_valid exactly 3 cycles after accept.
  - 40490FDB (pi) → 0003243F, status 20 (inexact).
- Range limits:
  - 477FFF00 (65535.0) → FFFF0000, status 00.
  - 47800000 (65536.0) → FFFFFFFF, status 30.
  - 7F800000 (+inf) → FFFFFFFF, status 10.
- Small values:
  - 37800000 (2^-16) → 00000001, status 00.
  - 37000000 (2^-17) → 0, status 29.
  - 00000001 (denorm) → 0, status 29.
  - 80000000 (−0) → 0, status 01.
- Invalid inputs:
  - BF800000 → 0, status 04.
  - 7FC00000 → FFFFFFFF, status 04.
- Backpressure: stream 6 operands back-to-back while out_ready is held 0 for 5 cycles after the first out_valid.
  - in_ready must fall the same cycle the stall begins.
  - Held out_data must not change.
  - All 6 results must emerge in order with none lost or duplicated.
- Reset: assert rst_n low for 1 cycle while 3 operands are in flight.
  - Outputs go to 0 immediately.
  - No stale result appears after release.
  - The next operand emerges with latency 3.
